// File: rtl/bound_tracker.sv
// -----------------------------------------------------------------------------
// bound_tracker
//
// Per-frame horizontal bound extractor for a flagged pixel stream. Target
// pixels are flagged upstream. Each row is passed through a run-length noise
// filter: a pixel is only accepted once it completes a run of RUN_MIN
// consecutive hits. The leftmost and rightmost accepted columns are tracked
// across the whole frame. After the frame's eop beat the tracker publishes the
// bounds with a one-cycle bounds_eop strobe.
//
// Handshake: a beat is transferred on every rising clk edge where
// pixel_valid=1. sop, eop and pixel_hit are don't-care while pixel_valid=0.
// There is no backpressure. Outputs are level signals that hold until the next
// publish. bounds_eop marks the single cycle in which they have just changed.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pixel_valid  qualifies sop/eop/pixel_hit this cycle
//   sop          beat is pixel (0,0) of a new frame
//   eop          beat is last pixel of the frame
//   pixel_hit    pixel classified as target colour
//   left_bound   leftmost accepted column of last completed frame
//   right_bound  rightmost accepted column of last completed frame
//   bounds_eop   one-cycle strobe, bounds just updated (high while in PUBLISH)
//   found        last completed frame contained at least one accepted run
//   hit_pixels   accepted-run pixel count of last frame, saturating
// -----------------------------------------------------------------------------
module bound_tracker #(
   parameter int IMAGE_W = 640,
   parameter int IMAGE_H = 480,
   parameter int RUN_MIN = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixel_valid,
   input  logic        sop,
   input  logic        eop,
   input  logic        pixel_hit,
   output logic [10:0] left_bound,
   output logic [10:0] right_bound,
   output logic        bounds_eop,
   output logic        found,
   output logic [19:0] hit_pixels
);

   localparam logic [10:0] X_LAST     = 11'(IMAGE_W - 1);
   localparam logic [10:0] Y_LAST     = 11'(IMAGE_H - 1);
   localparam logic [3:0]  RUN_MIN_L  = 4'(RUN_MIN);
   localparam logic [3:0]  RUN_MIN_M1 = 4'(RUN_MIN - 1);
   localparam logic [10:0] RUN_OFFSET = 11'(RUN_MIN - 1);
   localparam logic [20:0] RUN_ADD    = 21'(RUN_MIN);
   localparam logic [19:0] HIT_MAX    = 20'hF_FFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t      state_q, state_d;

   // Position, run filter and frame accumulators.
   logic [10:0] x_q, y_q;
   logic [3:0]  run_q;
   logic        any_q;
   logic [10:0] min_left_q, max_right_q;
   logic [19:0] hits_q;

   // Combinational view of the current beat.
   logic        take, restart, publish_now;
   logic [10:0] beat_x, beat_y, x_d, y_d;
   logic [3:0]  run_base, run_inc, run_d;
   logic        accept, first;
   logic [10:0] cand_left;
   logic        any_b, any_d;
   logic [10:0] min_b, min_d, max_b, max_d;
   logic [19:0] hits_b, hits_d;
   logic [20:0] hits_sum;

   // Outside SCAN only a sop beat is consumed; everything else is dropped.
   always_comb begin
      take        = pixel_valid && ((state_q == SCAN) || sop);
      restart     = pixel_valid && sop;
      publish_now = take && eop;

      beat_x = restart ? 11'd0 : x_q;
      beat_y = restart ? 11'd0 : y_q;

      // Runs never span rows: column 0 always starts a fresh run.
      run_base = (beat_x == 11'd0) ? 4'd0 : run_q;
      run_inc  = (run_base == 4'hF) ? 4'hF : run_base + 4'd1;
      run_d    = pixel_hit ? run_inc : 4'd0;
      accept   = pixel_hit && (run_inc >= RUN_MIN_L);
      // The beat that brings the run to exactly RUN_MIN. Tested on the
      // pre-increment length so a run saturated at 15 never re-triggers.
      first    = pixel_hit && (run_base == RUN_MIN_M1);

      // Acceptance implies beat_x >= RUN_MIN-1, so this cannot underflow.
      cand_left = beat_x - RUN_OFFSET;

      // A sop beat discards whatever the previous (partial) frame collected.
      any_b  = restart ? 1'b0 : any_q;
      min_b  = restart ? 11'h7FF : min_left_q;
      max_b  = restart ? 11'd0 : max_right_q;
      hits_b = restart ? 20'd0 : hits_q;

      any_d = any_b | accept;

      min_d = min_b;
      if (first && (cand_left < min_b)) min_d = cand_left;

      max_d = max_b;
      if (accept && (beat_x > max_b)) max_d = beat_x;

      hits_sum = 21'd0;
      if (first)       hits_sum = {1'b0, hits_b} + RUN_ADD;
      else if (accept) hits_sum = {1'b0, hits_b} + 21'd1;
      if (!accept)               hits_d = hits_b;
      else if (hits_sum[20] || (hits_sum[19:0] == HIT_MAX)) hits_d = HIT_MAX;
      else                       hits_d = hits_sum[19:0];

      // Rows past the last one are folded onto the last row.
      if (beat_x == X_LAST) begin
         x_d = 11'd0;
         y_d = (beat_y == Y_LAST) ? beat_y : beat_y + 11'd1;
      end else begin
         x_d = beat_x + 11'd1;
         y_d = beat_y;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (take) state_d = eop ? PUBLISH : SCAN;
         SCAN:    if (publish_now) state_d = PUBLISH;
         // A sop in the publish cycle starts the next frame without a gap.
         PUBLISH: state_d = take ? (eop ? PUBLISH : SCAN) : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         x_q         <= 11'd0;
         y_q         <= 11'd0;
         run_q       <= 4'd0;
         any_q       <= 1'b0;
         min_left_q  <= 11'h7FF;
         max_right_q <= 11'd0;
         hits_q      <= 20'd0;
      end else begin
         state_q <= state_d;
         if (take) begin
            x_q         <= x_d;
            y_q         <= y_d;
            run_q       <= run_d;
            any_q       <= any_d;
            min_left_q  <= min_d;
            max_right_q <= max_d;
            hits_q      <= hits_d;
         end
      end
   end

   // Results are captured from the accumulator values that already include
   // the eop beat, so they are visible during the PUBLISH cycle.
   // Full-width bounds mean "no target" to the downstream calculator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         left_bound  <= 11'd0;
         right_bound <= X_LAST;
         found       <= 1'b0;
         hit_pixels  <= 20'd0;
      end else if (publish_now) begin
         if (any_d) begin
            left_bound  <= min_d;
            right_bound <= max_d;
            found       <= 1'b1;
            hit_pixels  <= hits_d;
         end else begin
            left_bound  <= 11'd0;
            right_bound <= X_LAST;
            found       <= 1'b0;
            hit_pixels  <= 20'd0;
         end
      end
   end

   assign bounds_eop = (state_q == PUBLISH);

endmodule

// File: tb/tb_bound_tracker.sv
// -----------------------------------------------------------------------------
// tb_bound_tracker
//
// Frames are described as lists of hit segments (row, x0..x1). A segment is
// fully inside one row and does not touch another segment in that row.
// Expected publishes are derived from that description. A segment is accepted
// whole when its length reaches RUN_MIN. The expected publish is pushed to
// exp_q when the frame's eop is driven. A negedge monitor pushes every
// observed bounds_eop cycle to obs_q. Each test pops and compares the two
// queues. Frames end early with eop, so they are only a few rows tall. Rows
// beyond the eop never influence the bounds.
// -----------------------------------------------------------------------------
module tb_bound_tracker;

  localparam int W       = 640;
  localparam int H       = 480;
  localparam int RUN_MIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_valid, sop, eop, pixel_hit;
  logic [10:0] left_bound, right_bound;
  logic        bounds_eop, found;
  logic [19:0] hit_pixels;

  // Packed result: {found, hit_pixels, left_bound, right_bound}
  logic [42:0] exp_q[$];
  logic [42:0] obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int seg_row[8];
  int seg_x0[8];
  int seg_x1[8];
  int nseg = 0;

  bound_tracker #(.IMAGE_W(W), .IMAGE_H(H), .RUN_MIN(RUN_MIN)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .sop(sop), .eop(eop),
    .pixel_hit(pixel_hit), .left_bound(left_bound), .right_bound(right_bound),
    .bounds_eop(bounds_eop), .found(found), .hit_pixels(hit_pixels)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bounds_eop === 1'b1) obs_q.push_back({found, hit_pixels, left_bound, right_bound});
  end

  // ---------------- model ----------------
  task automatic clear_segs();
    nseg = 0;
  endtask

  task automatic add_seg(input int r, input int a, input int b);
    seg_row[nseg] = r; seg_x0[nseg] = a; seg_x1[nseg] = b;
    nseg++;
  endtask

  function automatic bit is_hit(input int r, input int x);
    for (int i = 0; i < nseg; i++)
      if (seg_row[i] == r && x >= seg_x0[i] && x <= seg_x1[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [42:0] model_frame(input int nrows);
    int lo = W, hi = -1, cnt = 0;
    for (int i = 0; i < nseg; i++) begin
      if (seg_row[i] < nrows && (seg_x1[i] - seg_x0[i] + 1) >= RUN_MIN) begin
        if (seg_x0[i] < lo) lo = seg_x0[i];
        if (seg_x1[i] > hi) hi = seg_x1[i];
        cnt += seg_x1[i] - seg_x0[i] + 1;
      end
    end
    if (hi < 0) return {1'b0, 20'd0, 11'd0, 11'(W - 1)};
    return {1'b1, 20'(cnt), 11'(lo), 11'(hi)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic beat(input bit s, input bit e, input bit h);
    pixel_valid = 1'b1; sop = s; eop = e; pixel_hit = h;
    @(posedge clk); #1;
  endtask

  // Invalid beat carrying random junk on the qualified signals.
  task automatic idle_beat();
    pixel_valid = 1'b0;
    sop = 1'($urandom_range(0, 1));
    eop = 1'($urandom_range(0, 1));
    pixel_hit = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic release_bus();
    pixel_valid = 1'b0; sop = 1'b0; eop = 1'b0; pixel_hit = 1'b0;
  endtask

  // Drives nrows full rows; stop_after >= 0 truncates the frame (no eop).
  task automatic drive_frame(input int nrows, input int stop_after, input bit gaps);
    int total = nrows * W;
    if (stop_after < 0) exp_q.push_back(model_frame(nrows));
    for (int b = 0; b < total; b++) begin
      if (stop_after >= 0 && b == stop_after) break;
      if (gaps && $urandom_range(0, 1) == 1) idle_beat();
      beat(b == 0, b == total - 1, is_hit(b / W, b % W));
    end
    release_bus();
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 4000 && obs_q.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    release_bus();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (left_bound !== 11'd0) begin n_fail++; $display("FAIL reset_left got %0d want 0", left_bound); end
    n_checks++; if (right_bound !== 11'(W - 1)) begin n_fail++; $display("FAIL reset_right got %0d want %0d", right_bound, W - 1); end
    n_checks++; if (found !== 1'b0) begin n_fail++; $display("FAIL reset_found got %b want 0", found); end
    n_checks++; if (hit_pixels !== 20'd0) begin n_fail++; $display("FAIL reset_hits got %0d want 0", hit_pixels); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bounds_eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop got %b want 0", bounds_eop); end
  endtask

  task automatic test_frames(input string name, input int nrows, input bit gaps);
    logic [42:0] got, want;
    drive_frame(nrows, -1, gaps);
    wait_obs(exp_q.size());
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count got %0d publishes want %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s got found=%b hits=%0d left=%0d right=%0d want found=%b hits=%0d left=%0d right=%0d",
                 name, got[42], got[41:22], got[21:11], got[10:0], want[42], want[41:22], want[21:11], want[10:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_restart();
    logic [42:0] got, want;
    clear_segs(); add_seg(0, 100, 120);
    drive_frame(2, 400, 1'b0);           // partial frame, no eop
    clear_segs(); add_seg(1, 300, 310);
    drive_frame(2, -1, 1'b0);            // sop straight away
    wait_obs(1);
    n_checks++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL restart_count got %0d publishes want 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL restart got left=%0d right=%0d hits=%0d want left=%0d right=%0d hits=%0d",
                 got[21:11], got[10:0], got[41:22], want[21:11], want[10:0], want[41:22]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    clear_segs(); add_seg(0, 100, 120); add_seg(1, 10, 30);
    drive_frame(3, 700, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    beat(1'b0, 1'b1, 1'b1);              // eop without sop: ignored
    for (int i = 0; i < 6; i++) beat(1'b0, 1'b0, 1'b1);
    release_bus();
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_publish got %0d publishes want 0", obs_q.size()); end
    n_checks++; if (left_bound !== 11'd0) begin n_fail++; $display("FAIL rstmid_left got %0d want 0", left_bound); end
    n_checks++; if (right_bound !== 11'(W - 1)) begin n_fail++; $display("FAIL rstmid_right got %0d want %0d", right_bound, W - 1); end
    n_checks++; if (found !== 1'b0) begin n_fail++; $display("FAIL rstmid_found got %b want 0", found); end
    n_checks++; if (hit_pixels !== 20'd0) begin n_fail++; $display("FAIL rstmid_hits got %0d want 0", hit_pixels); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [42:0] got, want;
    clear_segs(); add_seg(0, 10, 20);
    drive_frame(2, -1, 1'b0);
    clear_segs(); add_seg(1, 30, 35);    // sop lands in the PUBLISH cycle
    drive_frame(2, -1, 1'b0);
    wait_obs(2);
    n_checks++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d publishes want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b got left=%0d right=%0d hits=%0d want left=%0d right=%0d hits=%0d",
                 got[21:11], got[10:0], got[41:22], want[21:11], want[10:0], want[41:22]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    release_bus();
    test_reset();

    clear_segs(); add_seg(2, 200, 259);
    test_frames("single_run", 4, 1'b0);

    clear_segs();
    add_seg(1, 50, 52); add_seg(3, 50, 52); add_seg(5, 50, 52); add_seg(10, 400, 409);
    test_frames("short_runs", 11, 1'b0);

    clear_segs();
    test_frames("no_hits", 2, 1'b0);

    clear_segs(); add_seg(5, 636, 639); add_seg(6, 0, 1);
    test_frames("row_wrap", 7, 1'b0);

    test_restart();

    clear_segs(); add_seg(2, 200, 259);
    test_frames("valid_gaps", 4, 1'b1);

    test_reset_mid_frame();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bound_tracker.md
Name: bound_tracker

Overview:
- Per-frame bounding-bound extractor that sits between the colour-classification stage of the VIP pixel stream and the distance/centre calculator.
- Scans a pixel stream in which upstream has already flagged target-colour pixels.
- Applies a horizontal run-length noise filter, tracks the leftmost and rightmost accepted columns across the whole frame, and publishes left_bound/right_bound with a one-cycle eop strobe once the frame ends.
- The bounds and strobe are exactly the inputs the distance calculator consumes.

Parameters:
- IMAGE_W, 640, active pixels per row.
- IMAGE_H, 480, active rows per frame.
- RUN_MIN, 4, consecutive hit pixels in one row required before a run counts (1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pixel_valid  input  1  qualifies sop/eop/pixel_hit this cycle
- sop  input  1  beat is pixel (0,0) of a new frame
- eop  input  1  beat is last pixel of frame
- pixel_hit  input  1  pixel classified as target colour
- left_bound  output  11  leftmost accepted column of last completed frame
- right_bound  output  11  rightmost accepted column of last completed frame
- bounds_eop  output  1  one-cycle strobe: bounds just updated
- found  output  1  last completed frame contained at least one accepted run
- hit_pixels  output  20  accepted-run pixel count of last frame, saturating at 2^20-1

Behaviour:
- Reset values:
  - left_bound=0, right_bound=IMAGE_W-1, found=0, bounds_eop=0, hit_pixels=0.
  - Internal state IDLE, counters 0.
  - This no-target encoding (full-width bounds) is deliberate: the distance calculator rejects full-width bounds.
- Nothing advances while pixel_valid=0. sop, eop and pixel_hit are ignored when pixel_valid=0.
- State machine:
  - IDLE: waits for a valid sop beat. That beat is processed as x=0, y=0, and the state moves to SCAN. A valid eop in IDLE without sop is ignored.
  - SCAN: every valid beat is a pixel. After processing, x increments. When x=IMAGE_W-1 it wraps to 0 and y increments; y saturates at IMAGE_H-1 (extra rows are treated as the last row).
  - SCAN, valid eop beat: the beat is processed as a pixel, then the state moves to PUBLISH.
  - SCAN, valid sop beat: the partial frame is discarded without publishing, accumulators clear, the beat is taken as (0,0), and the state stays in SCAN.
  - SCAN, sop and eop on the same beat: treated as a one-pixel frame, then PUBLISH.
  - PUBLISH (one cycle): outputs are registered and bounds_eop=1, then the state returns to IDLE. If pixel_valid&sop arrives during PUBLISH, it is accepted as the new frame's (0,0) and the next state is SCAN (no lost frame).
- Run filter:
  - run_len (4 bits, saturating at 15) increments on hit and clears on non-hit or when x wraps to 0. It is evaluated on the current beat including that beat's hit.
  - A beat is accepted when run_len including the current beat is ≥ RUN_MIN.
  - On the first accepted beat of a run, candidate left = x-RUN_MIN+1. Every accepted beat gives candidate right = x.
  - Frame accumulators: min_left = min(min_left, candidate left), max_right = max(max_right, x), any = 1.
  - hit_pixels counts the RUN_MIN pixels on the first accepted beat, then +1 per further accepted beat, saturating.
  - Runs never span rows.
- Publish values:
  - If any=1: left_bound=min_left, right_bound=max_right, found=1.
  - Otherwise: left_bound=0, right_bound=IMAGE_W-1, found=0, hit_pixels=0.
- Latency: outputs change on the clock edge after the eop beat. They hold their values until the next publish or reset.
- Arithmetic: x and the bounds are 11 bits unsigned. The RUN_MIN subtraction cannot underflow because acceptance implies x ≥ RUN_MIN-1.
- Reset asserted mid-frame: returns immediately to reset values. The next frame requires a fresh sop.

Test Plan:
- Reset, then a 640x480 frame with hits only at row 100, x=200..259 -> one cycle after eop: left=200, right=259, found=1, hit_pixels=60, bounds_eop a single-cycle pulse.
- Frame with isolated 3-pixel hit runs (x=50..52 on several rows) plus a run x=400..409 on row 10 -> left=400, right=409, hit_pixels=10; the short runs are rejected.
- Frame with no hits -> left=0, right=639, found=0, hit_pixels=0, bounds_eop pulses.
- Run x=636..639 on row 5 continuing into x=0..1 on row 6 -> left=636, right=639; row 6 contributes nothing because 2 < RUN_MIN.
- New sop mid-frame after hits at x=100..120, then a clean frame with hits at x=300..310 -> one publish only, left=300, right=310. Also: pixel_valid toggled 50% on a repeat of the first scenario gives identical results.
- Reset asserted mid-SCAN, then eop without sop -> no bounds_eop, outputs stay at reset values. Also: PUBLISH cycle coinciding with the next sop -> the next frame's bounds are correct.
